// File: rtl/aes_spi_sequencer.sv
// ---------------------------------------------------------------------------
// aes_spi_sequencer
//
// Purpose:
//   Turns one AES job request (plaintext, key size, key) into the three-transfer
//   SPI sequence SEND -> WAIT -> REC on master_full, then returns ciphertext
//   and inverse-ciphertext on a valid/ready response port. A watchdog aborts
//   a transfer that never completes.
//
// Optional feature:
//   AES_SEQ_SELFCHECK_EN - when defined, the inverse-ciphertext returned in the
//   REC transfer is compared against the latched plaintext; a mismatch
//   reports rsp_err = 2'b11 (data still returned). When undefined the
//   comparator is absent and rsp_err never takes the value 2'b11.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_ready   job request handshake
//   req_plain/_key_size/_key  job payload (key MSB-aligned)
//   m_start/m_reset       start pulse and reset towards master_full
//   m_buzy/m_done         master_full status / transfer-complete pulse
//   m_data_in/m_data_out  frame shifted out / frame shifted in
//   rsp_valid/rsp_ready   response handshake
//   rsp_cipher/rsp_inv    result words captured in the REC transfer
//   rsp_err               00 ok, 01 bad key size, 10 timeout, 11 self-check
//   busy                  high whenever not idle
// ---------------------------------------------------------------------------
module aes_spi_sequencer #(
  parameter int FRAME_W     = 392,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [127:0]       req_plain,
  input  logic [7:0]         req_key_size,
  input  logic [255:0]       req_key,
  output logic               m_start,
  output logic               m_reset,
  input  logic               m_buzy,
  input  logic               m_done,
  output logic [FRAME_W-1:0] m_data_in,
  input  logic [FRAME_W-1:0] m_data_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [127:0]       rsp_cipher,
  output logic [127:0]       rsp_inv,
  output logic [1:0]         rsp_err,
  output logic               busy
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      GAP_LAST = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_REC  = 3'd3,
    S_GAP  = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e               state_q;
  state_e               next_ph_q;     // phase to start when the gap expires
  logic [3:0]           gap_cnt_q;
  logic [WD_W-1:0]      wdog_q;
  logic                 m_start_q;
  logic                 m_reset_q;     // one-cycle abort pulse after a timeout
  logic [FRAME_W-1:0]   m_data_in_q;
  logic                 rsp_valid_q;
  logic [127:0]         rsp_cipher_q;
  logic [127:0]         rsp_inv_q;
  logic [1:0]           rsp_err_q;
`ifdef AES_SEQ_SELFCHECK_EN
  logic [127:0]         plain_q;
`endif

  logic key_size_ok;
  logic unused_inputs;

  assign key_size_ok = (req_key_size == 8'd16) || (req_key_size == 8'd24) ||
                       (req_key_size == 8'd32);

  // Busy status and the outer frame bytes carry no information for this block.
  assign unused_inputs = ^{m_buzy, m_data_out[FRAME_W-1:384], m_data_out[127:0]};

  // req_ready is gated by reset directly so no job can be accepted during reset.
  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign m_start    = m_start_q;
  assign m_reset    = reset | m_reset_q;
  assign m_data_in  = m_data_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_cipher = rsp_cipher_q;
  assign rsp_inv    = rsp_inv_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

  // Sequencer FSM with watchdog, gap timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      next_ph_q    <= S_WAIT;
      gap_cnt_q    <= 4'd0;
      wdog_q       <= '0;
      m_start_q    <= 1'b0;
      m_reset_q    <= 1'b0;
      m_data_in_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_cipher_q <= 128'd0;
      rsp_inv_q    <= 128'd0;
      rsp_err_q    <= 2'b00;
`ifdef AES_SEQ_SELFCHECK_EN
      plain_q      <= 128'd0;
`endif
    end else begin
      // Pulses default low so neither can be high two cycles in a row.
      m_start_q <= 1'b0;
      m_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (key_size_ok) begin
              state_q     <= S_SEND;
              m_start_q   <= 1'b1;
              wdog_q      <= '0;
              m_data_in_q <= {req_plain, req_key_size, req_key};
`ifdef AES_SEQ_SELFCHECK_EN
              plain_q     <= req_plain;
`endif
            end else begin
              // Rejected job: answer immediately, master is never started.
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 2'b01;
              rsp_cipher_q <= 128'd0;
              rsp_inv_q    <= 128'd0;
            end
          end
        end
        S_SEND, S_WAIT, S_REC: begin
          // A completion arriving on the expiry cycle still counts as success.
          if (m_done) begin
            if (state_q == S_REC) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_cipher_q <= m_data_out[383:256];
              rsp_inv_q    <= m_data_out[255:128];
`ifdef AES_SEQ_SELFCHECK_EN
              rsp_err_q    <= (m_data_out[255:128] != plain_q) ? 2'b11 : 2'b00;
`else
              rsp_err_q    <= 2'b00;
`endif
            end else begin
              state_q   <= S_GAP;
              next_ph_q <= (state_q == S_SEND) ? S_WAIT : S_REC;
              gap_cnt_q <= 4'd0;
            end
          end else if (wdog_q == WD_LAST) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 2'b10;
            rsp_cipher_q <= 128'd0;
            rsp_inv_q    <= 128'd0;
            m_reset_q    <= 1'b1;
            m_data_in_q  <= '0;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_GAP: begin
          // WAIT and REC both shift out an all-zero frame.
          if (gap_cnt_q == GAP_LAST) begin
            state_q     <= next_ph_q;
            m_start_q   <= 1'b1;
            wdog_q      <= '0;
            m_data_in_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q      <= S_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_cipher_q <= 128'd0;
            rsp_inv_q    <= 128'd0;
            rsp_err_q    <= 2'b00;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_spi_sequencer
//
// Self-checking bench: a stub master_full/AES slave answers the SPI transfers
// with random completion delays, and an event/timestamp model predicts every
// DUT output each cycle. Directed jobs pin the model with literal results.
// ---------------------------------------------------------------------------
module tb_aes_spi_sequencer;

  localparam int FW  = 392;
  localparam int GAP = 2;
  localparam int TMO = 64;

  localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [127:0]  req_plain;
  logic [7:0]    req_key_size;
  logic [255:0]  req_key;
  logic          m_start;
  logic          m_reset;
  logic          m_buzy;
  logic          m_done;
  logic [FW-1:0] m_data_in;
  logic [FW-1:0] m_data_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [127:0]  rsp_cipher;
  logic [127:0]  rsp_inv;
  logic [1:0]    rsp_err;
  logic          busy;

  always #5 clk = ~clk;

  aes_spi_sequencer #(.FRAME_W(FW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_plain(req_plain),
    .req_key_size(req_key_size), .req_key(req_key),
    .m_start(m_start), .m_reset(m_reset), .m_buzy(m_buzy), .m_done(m_done),
    .m_data_in(m_data_in), .m_data_out(m_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cipher(rsp_cipher),
    .rsp_inv(rsp_inv), .rsp_err(rsp_err), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // model state (timestamps of expected events)
  bit           job_active = 1'b0;
  int           start_due  = -1;
  int           rsp_due    = -1;
  int           mreset_due = -1;
  bit           rsp_shown  = 1'b0;
  bit           x_open     = 1'b0;
  int           x_start    = 0;
  int           phase      = 0;
  logic [FW-1:0] e_frame   = '0;
  logic [127:0] e_cipher   = 128'd0;
  logic [127:0] e_inv      = 128'd0;
  logic [1:0]   e_err      = 2'b00;

  // stub slave state
  bit           s_open     = 1'b0;
  int           s_start    = 0;
  int           s_len      = 0;
  int           s_idx      = 0;
  bit           never_done = 1'b0;
  logic [127:0] f_plain    = 128'd0;
  logic [7:0]   f_size     = 8'd0;
  logic [255:0] f_key      = 256'd0;

  // statistics / captured results
  int           mstart_cnt = 0;
  int           mreset_cnt = 0;
  int           last_mstart_cyc = 0;
  int           hs_cyc = 0;
  int           rsp_cyc = 0;
  logic [127:0] last_cipher;
  logic [127:0] last_inv;
  logic [1:0]   last_err;

  task automatic check(input bit ok, input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom();
    return t[FW-1:0];
  endfunction

  // Stand-in for the AES slave: known vectors, otherwise a keyed mix that
  // ignores the unused low key bytes.
  function automatic logic [127:0] fake_aes(input logic [127:0] p, input logic [7:0] sz,
                                            input logic [255:0] k);
    logic [255:0] mk;
    case (sz)
      8'd16:   mk = {k[255:128], 128'd0};
      8'd24:   mk = {k[255:64], 64'd0};
      default: mk = k;
    endcase
    if (p == PLAIN && sz == 8'd16 && mk[255:128] == K128) return CT128;
    if (p == PLAIN && sz == 8'd24 && mk[255:64] == K192) return CT192;
    if (p == PLAIN && sz == 8'd32 && mk == K256) return CT256;
    return p ^ mk[255:128] ^ mk[127:0] ^ {16{sz}};
  endfunction

  task automatic stub_drive();
    m_done     = 1'b0;
    m_buzy     = s_open;
    m_data_out = rand_frame();
    if (s_open && cyc == s_start + s_len) begin
      m_done = 1'b1;
      if (s_idx == 2) m_data_out[383:128] = {fake_aes(f_plain, f_size, f_key), f_plain};
      s_open = 1'b0;
      s_idx  = (s_idx + 1) % 3;
    end else if (!s_open && !m_start && $urandom_range(0, 7) == 0) begin
      m_done = 1'b1;  // stray completion, must be ignored
    end
  endtask

  task automatic stub_observe();
    if (m_reset) begin
      s_open = 1'b0;
      s_idx  = 0;
    end else if (m_start) begin
      s_open  = 1'b1;
      s_start = cyc;
      s_len   = never_done ? 1000000 : int'($urandom_range(1, 6));
      if (s_idx == 0) {f_plain, f_size, f_key} = m_data_in;
    end
  endtask

  // Predict the outputs of the next cycle from this cycle's inputs.
  task automatic model_step();
    bit idle_now;
    if (reset) begin
      job_active = 1'b0; start_due = -1; rsp_due = -1; mreset_due = -1;
      rsp_shown  = 1'b0; x_open = 1'b0;
      return;
    end
    idle_now = !job_active;
    if (start_due == cyc) begin x_open = 1'b1; x_start = cyc; start_due = -1; end
    if (rsp_due == cyc) begin rsp_shown = 1'b1; rsp_due = -1; end
    if (x_open) begin
      if (m_done) begin
        x_open = 1'b0;
        if (phase < 2) begin
          phase++;
          start_due = cyc + GAP + 1;
          e_frame   = '0;
        end else begin
          rsp_due = cyc + 1;
          e_err   = 2'b00;
        end
      end else if (cyc - x_start == TMO - 1) begin
        x_open = 1'b0; rsp_due = cyc + 1; mreset_due = cyc + 1;
        e_err = 2'b10; e_cipher = 128'd0; e_inv = 128'd0;
      end
    end
    if (rsp_shown && rsp_ready) begin rsp_shown = 1'b0; job_active = 1'b0; end
    if (idle_now && req_valid) begin
      job_active = 1'b1;
      phase      = 0;
      if (req_key_size == 8'd16 || req_key_size == 8'd24 || req_key_size == 8'd32) begin
        start_due = cyc + 1;
        e_frame   = {req_plain, req_key_size, req_key};
        e_cipher  = fake_aes(req_plain, req_key_size, req_key);
        e_inv     = req_plain;
      end else begin
        rsp_due = cyc + 1;
        e_err   = 2'b01;
      end
    end
  endtask

  task automatic compare();
    bit e_rv;
    bit e_ms;
    e_rv = rsp_shown || (rsp_due == cyc);
    e_ms = (start_due == cyc);
    check(m_start === e_ms, "m_start", FW'(m_start), FW'(e_ms));
    check(rsp_valid === e_rv, "rsp_valid", FW'(rsp_valid), FW'(e_rv));
    check(m_reset === (reset || mreset_due == cyc), "m_reset", FW'(m_reset),
          FW'(reset || mreset_due == cyc));
    check(busy === job_active, "busy", FW'(busy), FW'(job_active));
    check(req_ready === (!job_active && !reset), "req_ready", FW'(req_ready),
          FW'(!job_active && !reset));
    if (e_ms || x_open) check(m_data_in === e_frame, "m_data_in", m_data_in, e_frame);
    if (e_rv) begin
      check(rsp_err === e_err, "rsp_err", FW'(rsp_err), FW'(e_err));
      if (e_err != 2'b01) begin
        check(rsp_cipher === e_cipher, "rsp_cipher", FW'(rsp_cipher), FW'(e_cipher));
        check(rsp_inv === e_inv, "rsp_inv", FW'(rsp_inv), FW'(e_inv));
      end
    end
    if (m_start === 1'b1) begin mstart_cnt++; last_mstart_cyc = cyc; end
    if (m_reset === 1'b1 && !reset) mreset_cnt++;
  endtask

  task automatic tick();
    stub_drive();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    stub_observe();
  endtask

  task automatic run_job(input logic [127:0] p, input logic [7:0] sz,
                         input logic [255:0] k, input int dly);
    int guard;
    req_plain = p; req_key_size = sz; req_key = k; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 500) begin tick(); guard++; end
    hs_cyc = cyc;
    tick();
    req_valid = 1'b0; req_plain = rand128(); req_key_size = 8'($urandom());
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 2000) begin tick(); guard++; end
    check(rsp_valid === 1'b1, "rsp_arrives", FW'(rsp_valid), FW'(1));
    rsp_cyc = cyc;
    repeat (dly) tick();
    last_cipher = rsp_cipher; last_inv = rsp_inv; last_err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int guard;
    logic [7:0] sz;
    reset = 1'b1; req_valid = 1'b0; req_plain = 128'd0; req_key_size = 8'd0;
    req_key = 256'd0; rsp_ready = 1'b0; m_done = 1'b0; m_buzy = 1'b0; m_data_out = '0;
    repeat (3) tick();
    check(req_ready === 1'b0 && m_reset === 1'b1 && rsp_valid === 1'b0 &&
          m_start === 1'b0 && busy === 1'b0 && m_data_in === '0, "reset_state",
          FW'({req_ready, m_reset, rsp_valid, m_start, busy}), FW'(5'b01000));
    reset = 1'b0;
    tick();

    // AES-128 / 192 / 256 known answers
    run_job(PLAIN, 8'd16, {K128, rand128()}, 0);
    check(last_cipher === CT128, "aes128_cipher", FW'(last_cipher), FW'(CT128));
    check(last_inv === PLAIN, "aes128_inv", FW'(last_inv), FW'(PLAIN));
    check(last_err === 2'b00, "aes128_err", FW'(last_err), FW'(2'b00));
    run_job(PLAIN, 8'd24, {K192, 64'(rand128())}, 1);
    check(last_cipher === CT192, "aes192_cipher", FW'(last_cipher), FW'(CT192));
    check(last_err === 2'b00, "aes192_err", FW'(last_err), FW'(2'b00));
    run_job(PLAIN, 8'd32, K256, 2);
    check(last_cipher === CT256, "aes256_cipher", FW'(last_cipher), FW'(CT256));
    check(last_err === 2'b00, "aes256_err", FW'(last_err), FW'(2'b00));

    // bad key size
    mstart_cnt = 0;
    run_job(PLAIN, 8'd20, K256, 0);
    check(last_err === 2'b01, "badsize_err", FW'(last_err), FW'(2'b01));
    check(rsp_cyc - hs_cyc == 1, "badsize_latency", FW'(rsp_cyc - hs_cyc), FW'(1));
    check(mstart_cnt == 0, "badsize_no_start", FW'(mstart_cnt), FW'(0));

    // watchdog expiry
    never_done = 1'b1; mreset_cnt = 0;
    run_job(rand128(), 8'd16, {rand128(), rand128()}, 0);
    never_done = 1'b0;
    check(last_err === 2'b10, "timeout_err", FW'(last_err), FW'(2'b10));
    check(rsp_cyc - last_mstart_cyc == 64, "timeout_latency",
          FW'(rsp_cyc - last_mstart_cyc), FW'(64));
    check(mreset_cnt == 1, "timeout_mreset_pulses", FW'(mreset_cnt), FW'(1));
    check(req_ready === 1'b1, "timeout_back_idle", FW'(req_ready), FW'(1));

    // response back-pressure: held 10 cycles, checked every cycle by the model
    run_job(rand128(), 8'd32, {rand128(), rand128()}, 10);

    // reset while the WAIT transfer is in flight
    req_plain = rand128(); req_key_size = 8'd24; req_key = {rand128(), rand128()};
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 500) begin tick(); guard++; end
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (!(s_idx == 1 && s_open) && guard < 500) begin tick(); guard++; end
    check(guard < 500, "reach_wait", FW'(guard), FW'(500));
    reset = 1'b1;
    tick(); tick();
    check(rsp_valid === 1'b0 && busy === 1'b0, "midreset_idle",
          FW'({rsp_valid, busy}), FW'(2'b00));
    reset = 1'b0;
    repeat (3) tick();
    run_job(PLAIN, 8'd16, {K128, rand128()}, 0);
    check(last_cipher === CT128, "post_reset_cipher", FW'(last_cipher), FW'(CT128));
    check(last_err === 2'b00, "post_reset_err", FW'(last_err), FW'(2'b00));

    // random jobs
    for (int j = 0; j < 30; j++) begin
      case ($urandom_range(0, 7))
        0, 1:    sz = 8'd16;
        2, 3:    sz = 8'd24;
        4, 5:    sz = 8'd32;
        6:       sz = 8'($urandom());
        default: sz = 8'd0;
      endcase
      run_job(rand128(), sz, {rand128(), rand128()}, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
